// File: rtl/dds_wave_ctrl.sv
// DDS phase-accumulator controller: steps the phase, addresses a sync sine ROM and
// re-times the returned word into a valid-qualified sample stream. Optional macro: DDS_DITHER_EN.
//
// state   | meaning
// IDLE    | accumulator held at 0, no addresses issued
// RUN     | accumulating, config accepted immediately or deferred to next wrap
// PEND    | accumulating, deferred config held in shadow until the next wrap
module dds_wave_ctrl #(
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PHASE_WIDTH-1:0] cfg_freq,
  input  logic [PHASE_WIDTH-1:0] cfg_phase,
  input  logic                   cfg_sync,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_data,
  output logic [DATA_WIDTH-1:0]  wave_data,
  output logic                   wave_valid,
  output logic                   cycle_start,
  output logic                   pending
);

  localparam int FRAC_W = PHASE_WIDTH - ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PHASE_WIDTH-1:0]  acc_q, acc_d;
  logic [PHASE_WIDTH-1:0]  freq_act_q, freq_act_d;
  logic [PHASE_WIDTH-1:0]  phase_act_q, phase_act_d;
  logic [PHASE_WIDTH-1:0]  shd_freq_q, shd_freq_d;
  logic [PHASE_WIDTH-1:0]  shd_phase_q, shd_phase_d;
  logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
  logic                    addr_vld_q, addr_vld_d;
  logic                    addr_wrap_q, addr_wrap_d;
  logic                    carry_q, carry_d;
  logic                    ready_q, ready_d;
  logic [ROM_LATENCY-1:0]  vld_pipe_q, vld_pipe_d;
  logic [ROM_LATENCY-1:0]  wrap_pipe_q, wrap_pipe_d;
  logic [DATA_WIDTH-1:0]   wave_data_q, wave_data_d;
  logic                    wave_valid_q, wave_valid_d;
  logic                    cycle_start_q, cycle_start_d;

  logic                    cfg_fire;
  logic                    issue;
  logic                    step_carry;
  logic [PHASE_WIDTH-1:0]  step_sum;
  logic [PHASE_WIDTH-1:0]  phase_sum;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [FRAC_W-1:0]       addr_frac_unused;

  assign cfg_ready   = ready_q & (state_q != ST_PEND);
  assign cfg_fire    = cfg_valid & cfg_ready;
  assign pending     = (state_q == ST_PEND);
  assign rom_addr    = rom_addr_q;
  assign wave_data   = wave_data_q;
  assign wave_valid  = wave_valid_q;
  assign cycle_start = cycle_start_q;
  assign ready_d     = 1'b1;

  assign {step_carry, step_sum} = {1'b0, acc_q} + {1'b0, freq_act_q};

`ifdef DDS_DITHER_EN
  localparam int DITH_LSB = FRAC_W - 16;
  logic [15:0] lfsr_q, lfsr_d;

  // Dither lands just below the address bits so it only perturbs truncation.
  assign phase_sum = acc_q + phase_act_q + (PHASE_WIDTH'(lfsr_q) << DITH_LSB);
  assign lfsr_d    = issue ? ({1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000))
                           : lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign phase_sum = acc_q + phase_act_q;
`endif

  assign {addr_next, addr_frac_unused} = phase_sum;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    freq_act_d  = freq_act_q;
    phase_act_d = phase_act_q;
    shd_freq_d  = shd_freq_q;
    shd_phase_d = shd_phase_q;
    rom_addr_d  = rom_addr_q;
    addr_vld_d  = 1'b0;
    addr_wrap_d = 1'b0;
    carry_d     = 1'b0;
    issue       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_fire) begin
          freq_act_d  = cfg_freq;
          phase_act_d = cfg_phase;
        end
        if (en) begin
          state_d = ST_RUN;
          issue   = 1'b1;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          if (cfg_fire) begin
            freq_act_d  = cfg_freq;
            phase_act_d = cfg_phase;
          end
        end else begin
          issue = 1'b1;
          if (cfg_fire && cfg_sync) begin
            shd_freq_d  = cfg_freq;
            shd_phase_d = cfg_phase;
            state_d     = ST_PEND;
          end else if (cfg_fire) begin
            freq_act_d  = cfg_freq;
            phase_act_d = cfg_phase;
          end
        end
      end
      ST_PEND: begin
        // A stop while waiting still honours the deferred config.
        if (!en) begin
          state_d     = ST_IDLE;
          acc_d       = '0;
          freq_act_d  = shd_freq_q;
          phase_act_d = shd_phase_q;
        end else begin
          issue = 1'b1;
          if (step_carry) begin
            freq_act_d  = shd_freq_q;
            phase_act_d = shd_phase_q;
            state_d     = ST_RUN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      acc_d       = step_sum;
      rom_addr_d  = addr_next;
      addr_vld_d  = 1'b1;
      addr_wrap_d = carry_q | (state_q == ST_IDLE);
      carry_d     = step_carry;
    end
  end

  generate
    if (ROM_LATENCY > 1) begin : g_pipe
      assign vld_pipe_d  = {vld_pipe_q[ROM_LATENCY-2:0], addr_vld_q};
      assign wrap_pipe_d = {wrap_pipe_q[ROM_LATENCY-2:0], addr_wrap_q};
    end else begin : g_nopipe
      assign vld_pipe_d  = addr_vld_q;
      assign wrap_pipe_d = addr_wrap_q;
    end
  endgenerate

  always_comb begin
    wave_valid_d  = vld_pipe_q[ROM_LATENCY-1];
    cycle_start_d = vld_pipe_q[ROM_LATENCY-1] & wrap_pipe_q[ROM_LATENCY-1];
    wave_data_d   = vld_pipe_q[ROM_LATENCY-1] ? rom_data : wave_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      freq_act_q    <= '0;
      phase_act_q   <= '0;
      shd_freq_q    <= '0;
      shd_phase_q   <= '0;
      rom_addr_q    <= '0;
      addr_vld_q    <= 1'b0;
      addr_wrap_q   <= 1'b0;
      carry_q       <= 1'b0;
      ready_q       <= 1'b0;
      vld_pipe_q    <= '0;
      wrap_pipe_q   <= '0;
      wave_data_q   <= '0;
      wave_valid_q  <= 1'b0;
      cycle_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      freq_act_q    <= freq_act_d;
      phase_act_q   <= phase_act_d;
      shd_freq_q    <= shd_freq_d;
      shd_phase_q   <= shd_phase_d;
      rom_addr_q    <= rom_addr_d;
      addr_vld_q    <= addr_vld_d;
      addr_wrap_q   <= addr_wrap_d;
      carry_q       <= carry_d;
      ready_q       <= ready_d;
      vld_pipe_q    <= vld_pipe_d;
      wrap_pipe_q   <= wrap_pipe_d;
      wave_data_q   <= wave_data_d;
      wave_valid_q  <= wave_valid_d;
      cycle_start_q <= cycle_start_d;
    end
  end

endmodule

// File: doc/dds_wave_ctrl.md
Name: dds_wave_ctrl

Overview:
Phase-accumulator (DDS) controller that sequences the single-port sine ROM (2048 x 8, synchronous read).
- Each running cycle it steps a phase accumulator, applies a phase offset and truncates to a ROM address.
- It re-times the returned ROM word into a valid-qualified sample stream for the HDMI waveform display path.
- Frequency and phase updates arrive over a valid/ready handshake. They are applied immediately, or glitch-free at the next accumulator wrap.

Parameters:
PHASE_WIDTH, 32, accumulator/tuning-word width
ADDR_WIDTH, 11, ROM address width (top bits of phase)
DATA_WIDTH, 8, ROM/sample data width
ROM_LATENCY, 1, ROM addr-to-data cycles (1 = no output reg, 2 = output reg)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
en  in  1  run enable; level
cfg_valid  in  1  config request
cfg_ready  out  1  config accepted when cfg_valid&cfg_ready
cfg_freq  in  PHASE_WIDTH  tuning word
cfg_phase  in  PHASE_WIDTH  phase offset
cfg_sync  in  1  1 = apply at next wrap, 0 = apply immediately
rom_addr  out  ADDR_WIDTH  to ROM addr (registered)
rom_data  in  DATA_WIDTH  from ROM rd_data
wave_data  out  DATA_WIDTH  sample (registered)
wave_valid  out  1  wave_data valid
cycle_start  out  1  with wave_valid: first sample of a new period
pending  out  1  sync config waiting for wrap

Behaviour:
- Reset (sync, rst=1 at edge): acc=0, freq_act=0, phase_act=0, shadow regs=0, rom_addr=0, wave_data=0, wave_valid=0, cycle_start=0, pending=0, cfg_ready=0, state=IDLE. cfg_ready=1 from the first cycle after rst deasserts.
- States:
  - IDLE: acc held 0; addr pipeline idle.
  - RUN: accumulating.
  - PEND: accumulating, shadow config held.
- cfg_ready=1 in IDLE/RUN, 0 in PEND and during reset. pending=1 iff state==PEND.
- Config accept in IDLE, or in RUN with cfg_sync=0: freq_act/phase_act load at that edge and take effect from the next cycle.
- Config accept in RUN with cfg_sync=1: load shadow, go PEND.
- PEND: on the edge where acc+freq_act carries out of PHASE_WIDTH (wrap), acc <= (acc+freq_act) mod 2^PHASE_WIDTH. Shadow copies to freq_act/phase_act at the same edge; go RUN.
- PEND with freq_act=0 never wraps; it stays PEND until en drops.
- IDLE→RUN on edge with en=1. RUN/PEND→IDLE on edge with en=0; acc cleared to 0.
- Leaving PEND via en=0: shadow is applied immediately, not lost.
- cfg accepted on the same edge en falls: applied immediately.
- Address path, per RUN/PEND edge:
  - acc <= acc + freq_act, modulo.
  - rom_addr <= top ADDR_WIDTH bits of (acc + phase_act), using pre-update acc.
  - addr_vld <= 1; addr_wrap <= (previous update carried) OR (first edge after IDLE).
- In IDLE: addr_vld <= 0; rom_addr holds its last value.
- Data path:
  - addr_vld/addr_wrap delayed ROM_LATENCY cycles.
  - At that point wave_data <= rom_data, wave_valid <= 1, cycle_start <= delayed wrap flag.
  - Otherwise wave_valid=0 and cycle_start=0; wave_data holds.
- Latency: first wave_valid is ROM_LATENCY+1 cycles after the en=1 edge.
- On en falling, in-flight samples drain: exactly ROM_LATENCY more valid samples after the last address.
- Reset mid-operation discards shadow and in-flight samples; no valid emitted after the reset edge.
- All adds are unsigned modulo 2^PHASE_WIDTH. Truncation only, no rounding.

Optional Feature:
DDS_DITHER_EN defined:
- 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), seeded 0xACE1 on rst, advances every RUN/PEND cycle.
- Its value is added into bits [PHASE_WIDTH-ADDR_WIDTH-1 : PHASE_WIDTH-ADDR_WIDTH-16] of (acc+phase_act) before truncation.
- Requires PHASE_WIDTH-ADDR_WIDTH >= 16.

Not defined:
- No LFSR; pure truncation; output bit-exact deterministic.
- Test Plan assumes not defined.

Test Plan:
- Reset: rst=1 for 3 cycles with en=1 → all outputs 0. cfg_ready=1 on the first cycle after release.
- Step per address: cfg_freq=0x0020_0000, cfg_phase=0, cfg_sync=0, then en=1 → rom_addr 0,1,2,…,2047,0. First wave_valid 2 cycles after en. cycle_start on sample 0 and every 2048th sample.
- Offset: cfg_freq=0x0040_0000, cfg_phase=0x8000_0000 → rom_addr 1024,1026,…. cycle_start every 1024 samples.
- Sync update: running freq=0x0020_0000, at addr 100 send freq=0x0040_0000 with cfg_sync=1 → cfg_ready=0 and pending=1 until wrap. Addresses continue …2047,0,2,4. cycle_start on the sample with addr 0.
- Stop/drain: en=0 at addr 500 → exactly 1 further wave_valid (ROM_LATENCY=1). Re-enable → restarts at addr 0 with cycle_start=1.
- Reset in PEND: rst=1 while pending=1 → pending=0, freq_act=0. Shadow is not applied after release.
